// File: rtl/vai_audit_rx.sv
// CCI-P Rx demux: steers memory responses by VMID tag and MMIO requests by address window
// to per-sub-AFU ports. Fixed 2-cycle latency, no back-pressure, no buffering.
package ccip_if_pkg;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [8:0]   t_ccip_tid;
  typedef logic [15:0]  t_ccip_mmioAddr;
  typedef logic [511:0] t_ccip_clData;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    t_ccip_mdata mdata;
  } t_ccip_c0_RspMemHdr;

  // MMIO requests reuse the c0 header bits with this layout.
  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic        format;
    logic        rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    t_ccip_mdata mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

module vai_audit_rx
  import ccip_if_pkg::*;
#(
  parameter int NUM_SUB_AFUS = 8,
  parameter int MMIO_SHIFT   = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  t_if_ccip_Rx up_RxPort,
  output t_if_ccip_Rx afu_RxPort [NUM_SUB_AFUS],
  output logic        orphan_rd_valid,
  output t_ccip_tid   orphan_rd_tid,
  output logic [31:0] drop_count
);
  localparam int          L          = $clog2(NUM_SUB_AFUS);
  localparam logic [15:0] MDATA_KEEP = 16'hFFFF >> L;
  localparam logic [15:0] ADDR_KEEP  = 16'((32'd1 << MMIO_SHIFT) - 32'd1);
  localparam logic [15:0] NUM_WIN    = 16'(NUM_SUB_AFUS);

  // Deassertion passes two sync flops, then one registered copy per lane.
  logic [1:0]              r_rst_sync;
  logic                    r_core_rst_n;
  logic [NUM_SUB_AFUS-1:0] r_lane_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync   <= '0;
      r_core_rst_n <= 1'b0;
      r_lane_rst_n <= '0;
    end else begin
      r_rst_sync   <= {r_rst_sync[0], 1'b1};
      r_core_rst_n <= r_rst_sync[1];
      r_lane_rst_n <= {NUM_SUB_AFUS{r_rst_sync[1]}};
    end
  end

  logic               r_s1_c0_alm;
  logic               r_s1_c1_alm;
  logic               r_s1_c0_rsp;
  logic               r_s1_mmio_rd;
  logic               r_s1_mmio_wr;
  logic               r_s1_c1_rsp;
  t_ccip_c0_RspMemHdr r_s1_c0_hdr;
  t_ccip_clData       r_s1_c0_data;
  t_ccip_c1_RspMemHdr r_s1_c1_hdr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_c0_alm  <= 1'b1;
      r_s1_c1_alm  <= 1'b1;
      r_s1_c0_rsp  <= 1'b0;
      r_s1_mmio_rd <= 1'b0;
      r_s1_mmio_wr <= 1'b0;
      r_s1_c1_rsp  <= 1'b0;
    end else if (!r_core_rst_n) begin
      r_s1_c0_alm  <= 1'b1;
      r_s1_c1_alm  <= 1'b1;
      r_s1_c0_rsp  <= 1'b0;
      r_s1_mmio_rd <= 1'b0;
      r_s1_mmio_wr <= 1'b0;
      r_s1_c1_rsp  <= 1'b0;
    end else begin
      r_s1_c0_alm  <= up_RxPort.c0TxAlmFull;
      r_s1_c1_alm  <= up_RxPort.c1TxAlmFull;
      r_s1_c0_rsp  <= up_RxPort.c0.rspValid;
      r_s1_mmio_rd <= up_RxPort.c0.mmioRdValid;
      r_s1_mmio_wr <= up_RxPort.c0.mmioWrValid;
      r_s1_c1_rsp  <= up_RxPort.c1.rspValid;
    end
  end

  always_ff @(posedge clk) begin
    r_s1_c0_hdr  <= up_RxPort.c0.hdr;
    r_s1_c0_data <= up_RxPort.c0.data;
    r_s1_c1_hdr  <= up_RxPort.c1.hdr;
  end

  t_ccip_c0_ReqMmioHdr w_s1_mmio_hdr;
  t_ccip_c0_ReqMmioHdr w_mmio_hdr_out;
  t_ccip_c0_RspMemHdr  w_mem_hdr_out;
  t_ccip_c0_RspMemHdr  w_c0_hdr_out;
  t_ccip_c1_RspMemHdr  w_c1_hdr_out;
  logic [L-1:0]        w_vmid_c0;
  logic [L-1:0]        w_vmid_c1;
  logic [15:0]         w_win;
  logic                w_win_ok;
  logic [L-1:0]        w_win_lane;
  logic                w_rd_win;
  logic                w_rsp_win;
  logic                w_orphan;
  logic [1:0]          w_n_evt;
  logic [1:0]          w_n_ok;
  logic [1:0]          w_drops;
  logic [32:0]         w_drop_sum;

  assign w_s1_mmio_hdr = t_ccip_c0_ReqMmioHdr'(r_s1_c0_hdr);
  assign w_vmid_c0     = r_s1_c0_hdr.mdata[15 -: L];
  assign w_vmid_c1     = r_s1_c1_hdr.mdata[15 -: L];
  assign w_win         = w_s1_mmio_hdr.address >> MMIO_SHIFT;
  assign w_win_ok      = (w_win != 16'd0) && (w_win <= NUM_WIN);
  assign w_win_lane    = L'(w_win - 16'd1);

  // Protocol forbids c0 collisions; if one happens, wr > rd > rsp wins.
  assign w_rd_win  = r_s1_mmio_rd && !r_s1_mmio_wr;
  assign w_rsp_win = r_s1_c0_rsp && !r_s1_mmio_wr && !r_s1_mmio_rd;
  assign w_orphan  = r_s1_mmio_rd && !(w_rd_win && w_win_ok);

  always_comb begin
    w_mem_hdr_out          = r_s1_c0_hdr;
    w_mem_hdr_out.mdata    = r_s1_c0_hdr.mdata & MDATA_KEEP;
    w_mmio_hdr_out         = w_s1_mmio_hdr;
    w_mmio_hdr_out.address = w_s1_mmio_hdr.address & ADDR_KEEP;
    w_c1_hdr_out           = r_s1_c1_hdr;
    w_c1_hdr_out.mdata     = r_s1_c1_hdr.mdata & MDATA_KEEP;
    if (r_s1_mmio_wr || r_s1_mmio_rd) begin
      w_c0_hdr_out = t_ccip_c0_RspMemHdr'(w_mmio_hdr_out);
    end else begin
      w_c0_hdr_out = w_mem_hdr_out;
    end
  end

  assign w_n_evt    = {1'b0, r_s1_mmio_wr} + {1'b0, r_s1_mmio_rd} + {1'b0, r_s1_c0_rsp};
  assign w_n_ok     = {1'b0, r_s1_mmio_wr && w_win_ok} + {1'b0, w_rd_win && w_win_ok}
                    + {1'b0, w_rsp_win};
  assign w_drops    = w_n_evt - w_n_ok;
  assign w_drop_sum = {1'b0, drop_count} + {31'd0, w_drops};

  logic r_orphan_vld;
  logic [31:0] r_drop_count;
  t_ccip_tid r_orphan_tid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_orphan_vld <= 1'b0;
      r_drop_count <= '0;
    end else if (!r_core_rst_n) begin
      r_orphan_vld <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_orphan_vld <= w_orphan;
      r_drop_count <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    r_orphan_tid <= w_s1_mmio_hdr.tid;
  end

  assign orphan_rd_valid = r_orphan_vld;
  assign orphan_rd_tid   = r_orphan_tid;
  assign drop_count      = r_drop_count;

  for (genvar n = 0; n < NUM_SUB_AFUS; n++) begin : g_lane
    logic               r_c0_alm;
    logic               r_c1_alm;
    logic               r_c0_rsp;
    logic               r_mmio_rd;
    logic               r_mmio_wr;
    logic               r_c1_rsp;
    t_ccip_c0_RspMemHdr r_c0_hdr;
    t_ccip_clData       r_c0_data;
    t_ccip_c1_RspMemHdr r_c1_hdr;

    // Almost-full held high in reset so sub-AFUs stay quiet.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_c0_alm  <= 1'b1;
        r_c1_alm  <= 1'b1;
        r_c0_rsp  <= 1'b0;
        r_mmio_rd <= 1'b0;
        r_mmio_wr <= 1'b0;
        r_c1_rsp  <= 1'b0;
      end else if (!r_lane_rst_n[n]) begin
        r_c0_alm  <= 1'b1;
        r_c1_alm  <= 1'b1;
        r_c0_rsp  <= 1'b0;
        r_mmio_rd <= 1'b0;
        r_mmio_wr <= 1'b0;
        r_c1_rsp  <= 1'b0;
      end else begin
        r_c0_alm  <= r_s1_c0_alm;
        r_c1_alm  <= r_s1_c1_alm;
        r_c0_rsp  <= w_rsp_win && (w_vmid_c0 == L'(n));
        r_mmio_wr <= r_s1_mmio_wr && w_win_ok && (w_win_lane == L'(n));
        r_mmio_rd <= w_rd_win && w_win_ok && (w_win_lane == L'(n));
        r_c1_rsp  <= r_s1_c1_rsp && (w_vmid_c1 == L'(n));
      end
    end

    always_ff @(posedge clk) begin
      r_c0_hdr  <= w_c0_hdr_out;
      r_c0_data <= r_s1_c0_data;
      r_c1_hdr  <= w_c1_hdr_out;
    end

    assign afu_RxPort[n] = '{
      c0TxAlmFull: r_c0_alm,
      c1TxAlmFull: r_c1_alm,
      c0: '{hdr: r_c0_hdr, data: r_c0_data, rspValid: r_c0_rsp,
            mmioRdValid: r_mmio_rd, mmioWrValid: r_mmio_wr},
      c1: '{hdr: r_c1_hdr, rspValid: r_c1_rsp}
    };
  end

endmodule
